alarm_ctrl: RTL and testbench
=============================

ALARM_CTRL -- requirements
Module: alarm_ctrl

Interface
REQ-001 Parameters, SHALL be: SNOOZE_MIN, 5, minutes added per snooze (1..59).
REQ-002 Parameters, SHALL be: RING_SEC, 60, seconds of ringing before auto-stop.
REQ-003 Parameters, SHALL be: MAX_SNOOZE, 3, maximum snoozes per alarm event.
REQ-004 Ports SHALL be: clk  in  1  single system clock, same clock as the time-of-day counter.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 sec  in  6  current seconds, 0..59, from the time-of-day counter.
REQ-007 min  in  6  current minutes, 0..59.
REQ-008 hr  in  5  current hours, 0..23.
REQ-009 set_en  in  1  one-cycle load strobe for the alarm time.
REQ-010 set_hr  in  5 / set_min  in  6  alarm time to load.
REQ-011 arm  in  1  level: 1 = alarm enabled, 0 = disabled.
REQ-012 snooze  in  1 / stop  in  1  user buttons, sampled each clk.
REQ-013 buzz  out  1  high while ringing.
REQ-014 armed  out  1  high in ARMED, RINGING or SNOOZE.
REQ-015 state  out  2  current FSM state.
REQ-016 snooze_cnt  out  2  snoozes used in the current event.
REQ-017 alm_hr  out  5 / alm_min  out  6  stored alarm time readback.
REQ-018 set_err  out  1  one-cycle pulse on a rejected load.

Function
REQ-019 A second edge SHALL be detected when sec differs from its value registered on the previous clk; all timing in this block SHALL count second edges only.
REQ-020 FSM states SHALL be IDLE=0, ARMED=1, RINGING=2, SNOOZE=3.
REQ-021 Transition IDLE->ARMED SHALL occur when arm=1.
REQ-022 Transition ARMED->RINGING SHALL occur on a second edge where hr==alm_hr, min==alm_min and sec==0.
REQ-023 RINGING SHALL assert buzz combinationally from the state register, so buzz rises the cycle after the match edge.
REQ-024 In RINGING, stop=1 SHALL go to ARMED and clear snooze_cnt.
REQ-025 In RINGING, snooze=1 with snooze_cnt<MAX_SNOOZE SHALL load the snooze target, increment snooze_cnt and go to SNOOZE.
REQ-026 In RINGING, snooze=1 with snooze_cnt==MAX_SNOOZE SHALL be ignored.
REQ-027 In RINGING, RING_SEC second edges without stop or snooze SHALL go to ARMED and clear snooze_cnt.
REQ-028 Snooze target SHALL equal the current hr:min + SNOOZE_MIN, with minute wrap 59->0 carrying into hr and hr wrap 23->0.
REQ-029 The snooze target SHALL be held separately and SHALL NOT overwrite alm_hr/alm_min.
REQ-030 SNOOZE->RINGING SHALL occur on a second edge matching the snooze target with sec==0; the ring counter SHALL restart at 0.
REQ-031 arm=0 SHALL force IDLE from any state, clearing buzz and snooze_cnt.
REQ-032 Priority SHALL be: arm=0 > stop > snooze > timeout/match.
REQ-033 set_en SHALL load alm_hr/alm_min only when state is IDLE or ARMED and set_hr<=23 and set_min<=59.
REQ-034 Otherwise, set_en SHALL leave the stored time unchanged and pulse set_err for one cycle.
REQ-035 A load coinciding with a match edge SHALL take effect and suppress that match.
REQ-036 The ring counter SHALL be wide enough for RING_SEC and SHALL saturate, never wrapping.

Reset
REQ-037 rst=1 SHALL asynchronously set state=IDLE, buzz=0, armed=0, snooze_cnt=0, set_err=0, alm_hr=0, alm_min=0, snooze target=0:00, ring counter=0 and prev_sec=0.
REQ-038 Reset asserted while RINGING SHALL drop buzz immediately, without waiting for clk.

Structure
REQ-039 Package alarm_pkg SHALL hold the state encoding, HR_MAX=23 and MIN_MAX=59.
REQ-040 One sub-module, alarm_time_add (hr:min plus minutes with wrap), SHALL be instantiated for the snooze target.

Verification
REQ-041 Scenario: alarm 07:30, arm=1, time reaches 07:30:00 -> buzz=1 next cycle, state=2.
REQ-042 Scenario: ringing, snooze at 07:30:10 -> state=3, snooze_cnt=1, buzz=0; at 07:35:00 -> buzz=1.
REQ-043 Scenario: alarm 23:58, SNOOZE_MIN=5, snooze -> rings again at 00:03:00; 4th snooze ignored with MAX_SNOOZE=3.
REQ-044 Scenario: ringing, no input for 60 second edges -> state=1, buzz=0, snooze_cnt=0.
REQ-045 Scenario: set_hr=24 or set_min=60 -> set_err pulse, alm unchanged; set_en while RINGING -> set_err.
REQ-046 Scenario: rst mid-ring -> buzz=0 asynchronously, all outputs at reset values; arm=0 while SNOOZE -> IDLE.

Source files
------------

// File: rtl/alarm_pkg.sv
// alarm_pkg: shared state encoding and time-of-day limits for the alarm block
package alarm_pkg;
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        RINGING = 2'd2,
        SNOOZE  = 2'd3
    } state_t;
    localparam int HR_MAX  = 23;
    localparam int MIN_MAX = 59;
endpackage

// File: rtl/alarm_time_add.sv
// alarm_time_add: hr:min plus a fixed minute offset (< 60) with minute and hour wrap
module alarm_time_add #(
    parameter int ADD_MIN = 5
) (
    input  logic [4:0] hr,
    input  logic [5:0] min,
    output logic [4:0] sum_hr,
    output logic [5:0] sum_min
);
    import alarm_pkg::*;
    logic [6:0] m;
    logic carry;
    always_comb begin
        m       = {1'b0, min} + 7'(ADD_MIN);
        carry   = m > 7'(MIN_MAX);
        sum_min = carry ? 6'(m - 7'(MIN_MAX + 1)) : m[5:0];
        sum_hr  = !carry ? hr : (hr == 5'(HR_MAX)) ? 5'd0 : hr + 5'd1;
    end
endmodule

// File: rtl/alarm_ctrl.sv
// alarm_ctrl: alarm clock controller with snooze, auto-stop and validated time load
module alarm_ctrl #(
    parameter int SNOOZE_MIN = 5,
    parameter int RING_SEC   = 60,
    parameter int MAX_SNOOZE = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] sec,
    input  logic [5:0] min,
    input  logic [4:0] hr,
    input  logic       set_en,
    input  logic [4:0] set_hr,
    input  logic [5:0] set_min,
    input  logic       arm,
    input  logic       snooze,
    input  logic       stop,
    output logic       buzz,
    output logic       armed,
    output logic [1:0] state,
    output logic [1:0] snooze_cnt,
    output logic [4:0] alm_hr,
    output logic [5:0] alm_min,
    output logic       set_err
);
    import alarm_pkg::*;
    localparam int RW = $clog2(RING_SEC + 1);
    localparam logic [RW-1:0] RING_MAX = RW'(RING_SEC);
    state_t st, st_nx;
    logic [5:0] prev_sec, snz_min, tgt_min;
    logic [4:0] snz_hr, tgt_hr;
    logic [RW-1:0] ring_cnt;
    logic sec_edge, load_ok, alm_hit, snz_hit, ring_done;
    logic clr_cnt, do_snz, ring_clr;
    alarm_time_add #(.ADD_MIN(SNOOZE_MIN)) u_add (
        .hr(hr), .min(min), .sum_hr(tgt_hr), .sum_min(tgt_min)
    );
    assign sec_edge  = sec != prev_sec;
    assign load_ok   = set_en && (st == IDLE || st == ARMED) && set_hr <= 5'(HR_MAX) && set_min <= 6'(MIN_MAX);
    // a coinciding load replaces the alarm time, so the old match must not fire
    assign alm_hit   = sec_edge && sec == 6'd0 && hr == alm_hr && min == alm_min && !load_ok;
    assign snz_hit   = sec_edge && sec == 6'd0 && hr == snz_hr && min == snz_min;
    assign ring_done = sec_edge && ring_cnt >= RING_MAX - RW'(1);
    assign buzz      = st == RINGING;
    assign armed     = st != IDLE;
    assign state     = st;
    always_comb begin
        st_nx    = st;
        clr_cnt  = 1'b0;
        do_snz   = 1'b0;
        ring_clr = 1'b0;
        if (!arm) begin
            st_nx   = IDLE;
            clr_cnt = 1'b1;
        end else begin
            case (st)
                IDLE:    st_nx = ARMED;
                ARMED:   if (alm_hit) begin
                    st_nx    = RINGING;
                    ring_clr = 1'b1;
                end
                RINGING: if (stop || (!(snooze && snooze_cnt < 2'(MAX_SNOOZE)) && ring_done)) begin
                    st_nx   = ARMED;
                    clr_cnt = 1'b1;
                end else if (snooze && snooze_cnt < 2'(MAX_SNOOZE)) begin
                    st_nx  = SNOOZE;
                    do_snz = 1'b1;
                end
                SNOOZE:  if (snz_hit) begin
                    st_nx    = RINGING;
                    ring_clr = 1'b1;
                end
                default: st_nx = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st         <= IDLE;
            prev_sec   <= '0;
            snooze_cnt <= '0;
            alm_hr     <= '0;
            alm_min    <= '0;
            snz_hr     <= '0;
            snz_min    <= '0;
            ring_cnt   <= '0;
            set_err    <= 1'b0;
        end else begin
            st         <= st_nx;
            prev_sec   <= sec;
            set_err    <= set_en && !load_ok;
            snooze_cnt <= clr_cnt ? 2'd0 : do_snz ? snooze_cnt + 2'd1 : snooze_cnt;
            if (load_ok) begin
                alm_hr  <= set_hr;
                alm_min <= set_min;
            end
            if (do_snz) begin
                snz_hr  <= tgt_hr;
                snz_min <= tgt_min;
            end
            if (ring_clr)
                ring_cnt <= '0;
            else if (st == RINGING && sec_edge && ring_cnt != RING_MAX)
                ring_cnt <= ring_cnt + RW'(1);
        end
    end
endmodule

// File: tb/tb_alarm_ctrl.sv
// tb_alarm_ctrl: directed scenario bench for alarm_ctrl
module tb_alarm_ctrl;
    logic clk, rst, set_en, arm, snooze, stop;
    logic [5:0] sec, min, set_min;
    logic [4:0] hr, set_hr;
    logic buzz, armed, set_err;
    logic [1:0] state, snooze_cnt;
    logic [4:0] alm_hr;
    logic [5:0] alm_min;
    int n_cmp, n_bad;
    alarm_ctrl dut (
        .clk(clk), .rst(rst), .sec(sec), .min(min), .hr(hr),
        .set_en(set_en), .set_hr(set_hr), .set_min(set_min),
        .arm(arm), .snooze(snooze), .stop(stop),
        .buzz(buzz), .armed(armed), .state(state), .snooze_cnt(snooze_cnt),
        .alm_hr(alm_hr), .alm_min(alm_min), .set_err(set_err)
    );
    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end
    task automatic tick;
        @(posedge clk);
        #1;
    endtask
    task automatic settime(input int h, input int m, input int s);
        hr = 5'(h); min = 6'(m); sec = 6'(s);
        tick();
    endtask
    task automatic load(input int h, input int m);
        set_hr = 5'(h); set_min = 6'(m); set_en = 1;
        tick();
        set_en = 0;
    endtask
    task automatic press_snooze;
        snooze = 1; tick(); snooze = 0;
    endtask
    task automatic chk_state(input string nm, input logic [1:0] e);
        n_cmp++;
        if (state !== e) begin n_bad++; $display("FAIL %s state=%0d want %0d", nm, state, e); end
    endtask
    task automatic test_reset;
        n_cmp++;
        if ({state, buzz, armed, snooze_cnt, set_err, alm_hr, alm_min} !== 18'd0) begin
            n_bad++;
            $display("FAIL reset st=%0d buzz=%b armed=%b cnt=%0d err=%b alm=%0d:%0d want all 0",
                     state, buzz, armed, snooze_cnt, set_err, alm_hr, alm_min);
        end
        rst = 0;
        tick();
    endtask
    task automatic test_ring;
        load(7, 30);
        n_cmp++;
        if (alm_hr !== 5'd7 || alm_min !== 6'd30 || set_err !== 1'b0) begin
            n_bad++; $display("FAIL load alm=%0d:%0d err=%b want 7:30 0", alm_hr, alm_min, set_err);
        end
        arm = 1;
        tick();
        chk_state("arm", 2'd1);
        n_cmp++;
        if (armed !== 1'b1) begin n_bad++; $display("FAIL armed=%b want 1", armed); end
        settime(7, 29, 59);
        n_cmp++;
        if (buzz !== 1'b0) begin n_bad++; $display("FAIL pre_match buzz=%b want 0", buzz); end
        settime(7, 30, 0);
        chk_state("match", 2'd2);
        n_cmp++;
        if (buzz !== 1'b1) begin n_bad++; $display("FAIL match buzz=%b want 1", buzz); end
    endtask
    task automatic test_snooze;
        settime(7, 30, 10);
        press_snooze();
        chk_state("snooze", 2'd3);
        n_cmp++;
        if (snooze_cnt !== 2'd1 || buzz !== 1'b0 || alm_min !== 6'd30) begin
            n_bad++; $display("FAIL snooze cnt=%0d buzz=%b alm_min=%0d want 1 0 30", snooze_cnt, buzz, alm_min);
        end
        settime(7, 34, 59);
        chk_state("snooze_wait", 2'd3);
        settime(7, 35, 0);
        n_cmp++;
        if (buzz !== 1'b1) begin n_bad++; $display("FAIL rering buzz=%b want 1", buzz); end
        stop = 1; tick(); stop = 0;
        chk_state("stop", 2'd1);
        n_cmp++;
        if (snooze_cnt !== 2'd0) begin n_bad++; $display("FAIL stop cnt=%0d want 0", snooze_cnt); end
    endtask
    task automatic test_timeout;
        load(8, 0);
        settime(7, 59, 59);
        settime(8, 0, 0);
        chk_state("to_match", 2'd2);
        settime(8, 0, 1);
        press_snooze();
        settime(8, 4, 59);
        settime(8, 5, 0);
        chk_state("to_rering", 2'd2);
        for (int s = 1; s < 60; s++) settime(8, 5, s);
        chk_state("to_59", 2'd2);
        settime(8, 6, 0);
        chk_state("to_60", 2'd1);
        n_cmp++;
        if (buzz !== 1'b0 || snooze_cnt !== 2'd0) begin
            n_bad++; $display("FAIL timeout buzz=%b cnt=%0d want 0 0", buzz, snooze_cnt);
        end
    endtask
    task automatic test_wrap;
        load(23, 58);
        settime(23, 57, 59);
        settime(23, 58, 0);
        chk_state("wrap_match", 2'd2);
        for (int i = 1; i <= 3; i++) begin
            press_snooze();
            n_cmp++;
            if (state !== 2'd3 || snooze_cnt !== 2'(i)) begin
                n_bad++; $display("FAIL wrap_snooze%0d st=%0d cnt=%0d want 3 %0d", i, state, snooze_cnt, i);
            end
            settime(0, 5 * i - 3, 59);
            chk_state("wrap_wait", 2'd3);
            settime(0, 5 * i - 2, 0);
            chk_state("wrap_ring", 2'd2);
        end
        press_snooze();
        chk_state("snooze4", 2'd2);
        n_cmp++;
        if (snooze_cnt !== 2'd3 || alm_hr !== 5'd23 || alm_min !== 6'd58) begin
            n_bad++; $display("FAIL snooze4 cnt=%0d alm=%0d:%0d want 3 23:58", snooze_cnt, alm_hr, alm_min);
        end
        stop = 1; tick(); stop = 0;
        chk_state("wrap_stop", 2'd1);
    endtask
    task automatic test_set_err;
        load(24, 0);
        n_cmp++;
        if (set_err !== 1'b1 || alm_hr !== 5'd23 || alm_min !== 6'd58) begin
            n_bad++; $display("FAIL bad_hr err=%b alm=%0d:%0d want 1 23:58", set_err, alm_hr, alm_min);
        end
        tick();
        n_cmp++;
        if (set_err !== 1'b0) begin n_bad++; $display("FAIL err_pulse err=%b want 0", set_err); end
        load(5, 60);
        n_cmp++;
        if (set_err !== 1'b1 || alm_min !== 6'd58) begin
            n_bad++; $display("FAIL bad_min err=%b alm_min=%0d want 1 58", set_err, alm_min);
        end
        load(10, 1);
        settime(10, 0, 59);
        hr = 10; min = 1; sec = 0;
        load(11, 0);
        chk_state("load_suppress", 2'd1);
        n_cmp++;
        if (alm_hr !== 5'd11 || alm_min !== 6'd0) begin
            n_bad++; $display("FAIL load_suppress alm=%0d:%0d want 11:0", alm_hr, alm_min);
        end
        settime(10, 59, 59);
        settime(11, 0, 0);
        chk_state("ring_for_err", 2'd2);
        load(5, 0);
        n_cmp++;
        if (set_err !== 1'b1 || alm_hr !== 5'd11 || alm_min !== 6'd0) begin
            n_bad++; $display("FAIL ring_load err=%b alm=%0d:%0d want 1 11:0", set_err, alm_hr, alm_min);
        end
    endtask
    task automatic test_reset_ring;
        #2 rst = 1;
        #1;
        n_cmp++;
        if ({state, buzz, armed, snooze_cnt, alm_hr, alm_min} !== 17'd0) begin
            n_bad++;
            $display("FAIL async_rst st=%0d buzz=%b armed=%b cnt=%0d alm=%0d:%0d want all 0",
                     state, buzz, armed, snooze_cnt, alm_hr, alm_min);
        end
        rst = 0;
    endtask
    task automatic test_disarm;
        load(6, 0);
        chk_state("rearm", 2'd1);
        settime(5, 59, 59);
        settime(6, 0, 0);
        press_snooze();
        chk_state("dis_snooze", 2'd3);
        arm = 0;
        tick();
        chk_state("disarm", 2'd0);
        n_cmp++;
        if (snooze_cnt !== 2'd0 || armed !== 1'b0 || buzz !== 1'b0) begin
            n_bad++; $display("FAIL disarm cnt=%0d armed=%b buzz=%b want 0 0 0", snooze_cnt, armed, buzz);
        end
    endtask
    task automatic test_back_to_back;
        arm = 1;
        load(6, 1);
        settime(6, 0, 59);
        settime(6, 1, 0);
        chk_state("b2b_ring", 2'd2);
        stop = 1; snooze = 1;
        tick();
        stop = 0; snooze = 0;
        chk_state("stop_over_snooze", 2'd1);
        n_cmp++;
        if (snooze_cnt !== 2'd0) begin n_bad++; $display("FAIL stop_over_snooze cnt=%0d want 0", snooze_cnt); end
    endtask
    initial begin
        n_cmp = 0; n_bad = 0;
        rst = 1; set_en = 0; arm = 0; snooze = 0; stop = 0;
        sec = 0; min = 0; hr = 0; set_hr = 0; set_min = 0;
        #12;
        test_reset();
        test_ring();
        test_snooze();
        test_timeout();
        test_wrap();
        test_set_err();
        test_reset_ring();
        test_disarm();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
